// File: rtl/jacobian_transpose_update.sv
// rtl/jacobian_transpose_update.sv - Jacobian-transpose IK step: dtheta = alpha * J^T * clamp(tgt - cur)
// One shared signed MAC walks joints (outer) and task dims (inner), then one scaling pass per joint.
module jacobian_transpose_update #(
  parameter int          FRAC      = 16,
  parameter logic [26:0] ERR_CLAMP = 27'd65536,
  parameter logic [26:0] TOL       = 27'd64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [5:0][5:0][35:0] jacobian_matrix,
  input  logic [5:0][26:0]      cur_pose,
  input  logic [5:0][26:0]      tgt_pose,
  input  logic [5:0][26:0]      theta_in,
  input  logic [17:0]           alpha,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic [5:0][26:0]      dtheta,
  output logic [5:0][26:0]      theta_out
);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MAC, S_SCALE, S_DONE} state_t;

  localparam logic signed [27:0] LP_CLAMP = $signed({1'b0, ERR_CLAMP});
  localparam logic signed [27:0] LP_TOL   = $signed({1'b0, TOL});
  localparam logic [2:0]         LP_LAST  = 3'd5;

  state_t                  r_state, w_next;
  logic [5:0][5:0][35:0]   r_jac;
  logic [5:0][26:0]        r_cur, r_tgt, r_theta;
  logic [17:0]             r_alpha;
  logic signed [26:0]      r_err [6];
  logic signed [65:0]      r_acc [6];
  logic [2:0]              r_i, r_j;
  logic                    r_conv;
  logic [5:0][26:0]        r_dtheta, r_theta_out;

  logic signed [27:0]      w_diff [6];
  logic signed [27:0]      w_e [6];
  logic                    w_all_conv;
  logic signed [35:0]      w_jv;
  logic signed [26:0]      w_ev;
  logic signed [62:0]      w_prod;
  logic signed [65:0]      w_prod_x;
  logic signed [65:0]      w_s;
  logic signed [18:0]      w_alpha_s;
  logic signed [84:0]      w_p;
  logic signed [26:0]      w_dth;
  logic signed [27:0]      w_sum;
  logic signed [26:0]      w_th_new;

  // Error is formed at 28 bits so tgt - cur cannot wrap before clamping.
  always_comb begin
    w_all_conv = 1'b1;
    for (int j = 0; j < 6; j++) begin
      w_diff[j] = $signed({r_tgt[j][26], r_tgt[j]}) - $signed({r_cur[j][26], r_cur[j]});
      if (w_diff[j] > LP_CLAMP)       w_e[j] = LP_CLAMP;
      else if (w_diff[j] < -LP_CLAMP) w_e[j] = -LP_CLAMP;
      else                            w_e[j] = w_diff[j];
      if (w_e[j] >= LP_TOL || w_e[j] <= -LP_TOL) w_all_conv = 1'b0;
    end
  end

  assign w_jv      = r_jac[r_j][r_i];
  assign w_ev      = r_err[r_j];
  assign w_prod    = w_jv * w_ev;
  assign w_prod_x  = {{3{w_prod[62]}}, w_prod};

  assign w_s       = r_acc[r_i] >>> FRAC;
  assign w_alpha_s = {1'b0, r_alpha};
  assign w_p       = (w_s * w_alpha_s) >>> 17;
  assign w_sum     = {r_theta[r_i][26], r_theta[r_i]} + {w_dth[26], w_dth};

  always_comb begin
    if (!w_p[84] && (|w_p[83:26]))     w_dth = 27'sh3FFFFFF;
    else if (w_p[84] && !(&w_p[83:26])) w_dth = 27'sh4000000;
    else                                w_dth = w_p[26:0];
    if (w_sum[27] != w_sum[26]) w_th_new = w_sum[27] ? 27'sh4000000 : 27'sh3FFFFFF;
    else                        w_th_new = w_sum[26:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_state <= S_IDLE;
    else if (en) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ERR;
      S_ERR:   w_next = w_all_conv ? S_DONE : S_MAC;
      S_MAC:   if (r_i == LP_LAST && r_j == LP_LAST) w_next = S_SCALE;
      S_SCALE: if (r_i == LP_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jac       <= '0;
      r_cur       <= '0;
      r_tgt       <= '0;
      r_theta     <= '0;
      r_alpha     <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_conv      <= 1'b0;
      r_dtheta    <= '0;
      r_theta_out <= '0;
      for (int k = 0; k < 6; k++) begin
        r_err[k] <= '0;
        r_acc[k] <= '0;
      end
    end else if (en) begin
      case (r_state)
        S_IDLE: if (start) begin
          r_jac   <= jacobian_matrix;
          r_cur   <= cur_pose;
          r_tgt   <= tgt_pose;
          r_theta <= theta_in;
          r_alpha <= alpha;
          r_conv  <= 1'b0;
        end
        S_ERR: begin
          for (int k = 0; k < 6; k++) r_err[k] <= w_e[k][26:0];
          r_i <= '0;
          r_j <= '0;
          if (w_all_conv) begin
            r_conv      <= 1'b1;
            r_dtheta    <= '0;
            r_theta_out <= r_theta;
          end
        end
        S_MAC: begin
          // First task dim loads the accumulator so no separate clear cycle is needed.
          r_acc[r_i] <= (r_j == 3'd0) ? w_prod_x : r_acc[r_i] + w_prod_x;
          if (r_j == LP_LAST) begin
            r_j <= '0;
            r_i <= (r_i == LP_LAST) ? 3'd0 : r_i + 3'd1;
          end else begin
            r_j <= r_j + 3'd1;
          end
        end
        S_SCALE: begin
          r_dtheta[r_i]    <= w_dth;
          r_theta_out[r_i] <= w_th_new;
          r_i              <= r_i + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign converged = r_conv;
  assign dtheta    = r_dtheta;
  assign theta_out = r_theta_out;

endmodule

// File: tb/tb_jacobian_transpose_update.sv
// tb/tb_jacobian_transpose_update.sv - scoreboard bench for jacobian_transpose_update
module tb_jacobian_transpose_update;

  logic                  clk = 1'b0;
  logic                  rst_n, en, start;
  logic [5:0][5:0][35:0] jm;
  logic [5:0][26:0]      cur, tgt, thi, dth, tho;
  logic [17:0]           alpha;
  logic                  busy, done, conv;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0][26:0] dth;
    logic [5:0][26:0] tho;
    logic             conv;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  jacobian_transpose_update dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .start           (start),
    .jacobian_matrix (jm),
    .cur_pose        (cur),
    .tgt_pose        (tgt),
    .theta_in        (thi),
    .alpha           (alpha),
    .busy            (busy),
    .done            (done),
    .converged       (conv),
    .dtheta          (dth),
    .theta_out       (tho)
  );

  function automatic exp_t model(input int cyc);
    exp_t r;
    logic signed [127:0] e [6];
    logic signed [127:0] d, acc, s, p, sum;
    bit all_small = 1'b1;
    for (int j = 0; j < 6; j++) begin
      d = $signed(tgt[j]) - $signed(cur[j]);
      if (d > 65536)  d = 65536;
      if (d < -65536) d = -65536;
      e[j] = d;
      if (d >= 64 || d <= -64) all_small = 1'b0;
    end
    r.cyc  = cyc;
    r.conv = all_small;
    if (all_small) begin
      r.dth = '0;
      r.tho = thi;
    end else begin
      for (int i = 0; i < 6; i++) begin
        acc = 0;
        for (int j = 0; j < 6; j++) acc = acc + $signed(jm[j][i]) * e[j];
        s = acc >>> 16;
        p = (s * $signed({1'b0, alpha})) >>> 17;
        if (p > 67108863)  p = 67108863;
        if (p < -67108864) p = -67108864;
        r.dth[i] = p[26:0];
        sum = $signed(thi[i]) + p;
        if (sum > 67108863)  sum = 67108863;
        if (sum < -67108864) sum = -67108864;
        r.tho[i] = sum[26:0];
      end
    end
    return r;
  endfunction

  task automatic clear_inputs();
    jm = '0; cur = '0; tgt = '0; thi = '0; alpha = '0;
  endtask

  task automatic set_identity();
    for (int i = 0; i < 6; i++) jm[i][i] = 36'd65536;
  endtask

  // Caller is at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic launch(input int cyc);
    sb.push_back(model(cyc));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 6; i++) jm[j][i] = 36'($urandom);
      cur[j] = 27'($urandom);
      tgt[j] = 27'($urandom);
      thi[j] = 27'($urandom);
    end
    alpha = 18'($urandom);
  endtask

  task automatic collect(input string name, input int stall_at, input int stall_len, input int poke_at);
    exp_t x;
    int   cnt  = 1;
    bit   seen = 1'b0;
    while (cnt < 300) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      en    = !(stall_at > 0 && cnt >= stall_at && cnt < stall_at + stall_len);
      start = (cnt == poke_at);
      @(negedge clk);
      cnt++;
    end
    en = 1'b1; start = 1'b0;
    x = sb.pop_front();
    total++;
    if (!seen || cnt != x.cyc) begin
      bad++; $display("FAIL %s latency: done seen=%0d in cycle %0d, expected cycle %0d", name, seen, cnt, x.cyc);
    end
    total++;
    if (dth !== x.dth) begin
      bad++; $display("FAIL %s dtheta: got %h expected %h", name, dth, x.dth);
    end
    total++;
    if (tho !== x.tho) begin
      bad++; $display("FAIL %s theta_out: got %h expected %h", name, tho, x.tho);
    end
    total++;
    if (conv !== x.conv || busy !== 1'b1) begin
      bad++; $display("FAIL %s converged/busy: got %b/%b expected %b/1", name, conv, busy, x.conv);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s after done: done=%b busy=%b expected 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; start = 1'b0;
    clear_inputs();
    @(negedge clk); @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || conv !== 1'b0 || dth !== '0 || tho !== '0) begin
      bad++; $display("FAIL reset: busy=%b done=%b conv=%b dth=%h tho=%h expected all 0", busy, done, conv, dth, tho);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    clear_inputs(); set_identity();
    tgt[0] = 27'd40000; cur[0] = 27'd7232;
    alpha = 18'd65536;
    launch(44);
    collect("identity", 0, 0, 0);
    total++;
    if (dth[0] !== 27'd16384 || tho[0] !== 27'd16384) begin
      bad++; $display("FAIL identity const: dth0=%0d tho0=%0d expected 16384/16384", dth[0], tho[0]);
    end
  endtask

  task automatic test_converged();
    clear_inputs(); set_identity();
    alpha = 18'd65536;
    for (int j = 0; j < 6; j++) begin
      tgt[j] = 27'($urandom_range(0, 1000000));
      cur[j] = tgt[j] + 27'd10;
      thi[j] = 27'($urandom);
    end
    launch(2);
    collect("converged", 0, 0, 0);
    total++;
    if (conv !== 1'b1) begin
      bad++; $display("FAIL converged flag: got %b expected 1", conv);
    end
  endtask

  task automatic test_clamp();
    clear_inputs(); set_identity();
    tgt[0] = 27'd10000000;
    alpha = 18'd131071;
    launch(44);
    collect("clamp", 0, 0, 0);
    total++;
    if (dth[0] !== 27'd65535) begin
      bad++; $display("FAIL clamp const: dth0=%0d expected 65535", dth[0]);
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    jm[0][0] = 36'h7FFFFFFFF;
    tgt[0]   = 27'd65536;
    alpha    = 18'd131071;
    thi[0]   = 27'd67108764;
    launch(44);
    collect("saturation", 0, 0, 0);
    total++;
    if (dth[0] !== 27'd67108863 || tho[0] !== 27'd67108863) begin
      bad++; $display("FAIL saturation const: dth0=%0d tho0=%0d expected 67108863", dth[0], tho[0]);
    end
  endtask

  task automatic test_alpha_zero();
    clear_inputs(); set_identity();
    cur[2] = 27'd5000;
    thi[2] = 27'd1234;
    launch(44);
    collect("alpha_zero", 0, 0, 0);
  endtask

  task automatic test_stall_ignore();
    clear_inputs(); set_identity();
    tgt[0] = 27'd32768; tgt[3] = 27'd1000;
    cur[4] = 27'd30000;
    jm[1][0] = 36'hFFFFF0000;
    alpha = 18'd65536;
    launch(49);
    collect("stall_ignore", 10, 5, 20);
  endtask

  task automatic test_reset_abort();
    int cnt = 1;
    int early = 0;
    clear_inputs(); set_identity();
    tgt[1] = 27'd20000;
    alpha  = 18'd100000;
    launch(44);
    void'(sb.pop_back());
    while (cnt < 20) begin
      if (done) early++;
      @(negedge clk);
      cnt++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || conv !== 1'b0 || dth !== '0 || tho !== '0) begin
      bad++; $display("FAIL abort in reset: busy=%b done=%b conv=%b dth=%h tho=%h expected all 0", busy, done, conv, dth, tho);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) early++;
    end
    total++;
    if (early != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort no done: done cycles=%0d busy=%b expected 0/0", early, busy);
    end
    clear_inputs(); set_identity();
    tgt[5] = 27'd50000; cur[5] = 27'd60000;
    alpha = 18'd65536;
    launch(44);
    collect("after_abort", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int   cnt = 1;
    clear_inputs(); set_identity();
    tgt[2] = 27'd30000;
    alpha  = 18'd65536;
    launch(44);
    while (cnt < 300 && !done) begin
      @(negedge clk);
      cnt++;
    end
    x = sb.pop_front();
    total++;
    if (cnt != x.cyc || dth !== x.dth) begin
      bad++; $display("FAIL b2b first: cycle %0d dth=%h expected cycle %0d dth=%h", cnt, dth, x.cyc, x.dth);
    end
    clear_inputs(); set_identity();
    tgt[3] = 27'd12345; cur[4] = 27'd2000;
    thi[3] = 27'd99;
    alpha = 18'd131071;
    sb.push_back(model(44));
    start = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b done-cycle start: busy=%b expected 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b accept: busy=%b expected 1", busy);
    end
    collect("b2b_second", 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0;
    clear_inputs();
    test_reset();
    test_identity();
    test_converged();
    test_clamp();
    test_saturation();
    test_alpha_zero();
    test_stall_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
